// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states,
// byte-lane geometry and small op-decode helpers.
package lsu_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;

    typedef enum logic [3:0] {
        OP_LB  = 4'b0000,
        OP_LH  = 4'b0001,
        OP_LW  = 4'b0010,
        OP_LBU = 4'b0100,
        OP_LHU = 4'b0101,
        OP_SB  = 4'b1000,
        OP_SH  = 4'b1001,
        OP_SW  = 4'b1010
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B    = 2'd0,
        SZ_H    = 2'd1,
        SZ_W    = 2'd2,
        SZ_NONE = 2'd3
    } size_e;

    function automatic logic op_is_load(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic size_e op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            OP_LW, OP_SW:         return SZ_W;
            default:              return SZ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, response and data-memory signals of the LSU grouped as one bundle.
interface lsu_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_op_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;

    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic [4:0]  resp_rd_o;
    logic        resp_we_o;
    logic        resp_misalign_o;

    logic        dmem_ren_o;
    logic        dmem_wen_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_we_mask_o;
    logic [31:0] dmem_rdata_i;

    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_rd_i,
        input  resp_ready_i, dmem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_rd_o, resp_we_o,
        output resp_misalign_o, dmem_ren_o, dmem_wen_o, dmem_addr_o,
        output dmem_wdata_o, dmem_we_mask_o
    );

    modport master (
        output req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_rd_i,
        output resp_ready_i, dmem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_rd_o, resp_we_o,
        input  resp_misalign_o, dmem_ren_o, dmem_wen_o, dmem_addr_o,
        input  dmem_wdata_o, dmem_we_mask_o
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store replication/mask and load extraction
// with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]       i_st_op,
    input  logic [1:0]       i_st_lo,
    input  logic [31:0]      i_st_data,
    output logic [31:0]      o_st_data,
    output logic [LANES-1:0] o_st_mask,
    input  logic [3:0]       i_ld_op,
    input  logic [1:0]       i_ld_lo,
    input  logic [31:0]      i_ld_data,
    output logic [31:0]      o_ld_data
);

    logic [BYTE_W-1:0]   w_byte;
    logic [2*BYTE_W-1:0] w_half;

    assign w_byte = i_ld_data[{i_ld_lo, 3'b000} +: BYTE_W];
    assign w_half = i_ld_data[{i_ld_lo[1], 4'b0000} +: 2*BYTE_W];

    // Store data replicated across lanes, mask selects the written lanes
    always_comb begin
        o_st_data = 32'h0000_0000;
        o_st_mask = 4'b0000;
        case (i_st_op)
            OP_SB: begin
                o_st_data = {4{i_st_data[7:0]}};
                o_st_mask = 4'b0001 << i_st_lo;
            end
            OP_SH: begin
                o_st_data = {2{i_st_data[15:0]}};
                o_st_mask = 4'b0011 << {i_st_lo[1], 1'b0};
            end
            OP_SW: begin
                o_st_data = i_st_data;
                o_st_mask = 4'b1111;
            end
            default: begin
                o_st_data = 32'h0000_0000;
                o_st_mask = 4'b0000;
            end
        endcase
    end

    // Load result taken from the addressed lane and extended to 32 bits
    always_comb begin
        o_ld_data = 32'h0000_0000;
        case (i_ld_op)
            OP_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_ld_data = {24'h00_0000, w_byte};
            OP_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_ld_data = {16'h0000, w_half};
            OP_LW:   o_ld_data = i_ld_data;
            default: o_ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: accepts one request, strobes data
// memory in the accept cycle and returns a registered response.
module lsu
    import lsu_pkg::*;
#(
    parameter bit MISALIGN_CHK = 1'b1
) (
    input  logic   clk_i,
    input  logic   rst_i,
    lsu_if.slave   bus
);

    state_e      r_state, w_next;
    logic [3:0]  r_op;
    logic [1:0]  r_lo;
    logic [4:0]  r_rd;
    logic        r_resp_valid, r_resp_we, r_resp_mis;
    logic [31:0] r_resp_rdata;
    logic [4:0]  r_resp_rd;

    size_e       w_size;
    logic [1:0]  w_lo;
    logic        w_mis, w_ready, w_accept, w_go_load, w_wen;
    logic [31:0] w_st_data, w_ld_data;
    logic [3:0]  w_st_mask;

    // Alignment check, or forced low address bits when checking is disabled
    always_comb begin
        w_size = op_size(bus.req_op_i);
        w_lo   = bus.req_addr_i[1:0];
        w_mis  = 1'b0;
        if (MISALIGN_CHK) begin
            w_mis = ((w_size == SZ_H) && bus.req_addr_i[0]) ||
                    ((w_size == SZ_W) && (bus.req_addr_i[1:0] != 2'b00));
        end else begin
            case (w_size)
                SZ_H:    w_lo = {bus.req_addr_i[1], 1'b0};
                SZ_W:    w_lo = 2'b00;
                default: w_lo = bus.req_addr_i[1:0];
            endcase
        end
    end

    assign w_ready   = (r_state == ST_IDLE) && !rst_i;
    assign w_accept  = bus.req_valid_i && w_ready;
    assign w_go_load = w_accept && op_is_load(bus.req_op_i) && !w_mis;
    assign w_wen     = w_accept && op_is_store(bus.req_op_i) && !w_mis;

    assign bus.req_ready_o    = w_ready;
    assign bus.dmem_ren_o     = w_go_load;
    assign bus.dmem_wen_o     = w_wen;
    assign bus.dmem_addr_o    = w_accept ? {bus.req_addr_i[31:2], 2'b00} : 32'h0000_0000;
    assign bus.dmem_wdata_o   = w_wen ? w_st_data : 32'h0000_0000;
    assign bus.dmem_we_mask_o = w_wen ? w_st_mask : 4'b0000;

    lsu_align u_align (
        .i_st_op   (bus.req_op_i),
        .i_st_lo   (w_lo),
        .i_st_data (bus.req_wdata_i),
        .o_st_data (w_st_data),
        .o_st_mask (w_st_mask),
        .i_ld_op   (r_op),
        .i_ld_lo   (r_lo),
        .i_ld_data (bus.dmem_rdata_i),
        .o_ld_data (w_ld_data)
    );

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_go_load) w_next = ST_LOAD;
                    else           w_next = ST_RESP;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOAD: w_next = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready_i) w_next = ST_IDLE;
                else                  w_next = ST_RESP;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, captured request fields and response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_op         <= 4'b0000;
            r_lo         <= 2'b00;
            r_rd         <= 5'd0;
            r_resp_valid <= 1'b0;
            r_resp_we    <= 1'b0;
            r_resp_mis   <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_rd    <= 5'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op <= bus.req_op_i;
                r_lo <= w_lo;
                r_rd <= bus.req_rd_i;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_go_load) begin
                        r_resp_valid <= 1'b1;
                        r_resp_we    <= 1'b0;
                        r_resp_mis   <= w_mis;
                        r_resp_rdata <= 32'h0000_0000;
                        r_resp_rd    <= bus.req_rd_i;
                    end
                end
                ST_LOAD: begin
                    r_resp_valid <= 1'b1;
                    r_resp_we    <= (r_rd != 5'd0);
                    r_resp_mis   <= 1'b0;
                    r_resp_rdata <= w_ld_data;
                    r_resp_rd    <= r_rd;
                end
                ST_RESP: begin
                    if (bus.resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_resp_we    <= 1'b0;
                        r_resp_mis   <= 1'b0;
                        r_resp_rdata <= 32'h0000_0000;
                        r_resp_rd    <= 5'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs forced low during the reset cycle itself
    assign bus.resp_valid_o    = r_resp_valid && !rst_i;
    assign bus.resp_we_o       = r_resp_we && !rst_i;
    assign bus.resp_misalign_o = r_resp_mis && !rst_i;
    assign bus.resp_rdata_o    = rst_i ? 32'h0000_0000 : r_resp_rdata;
    assign bus.resp_rd_o       = rst_i ? 5'd0 : r_resp_rd;

endmodule

// File: tb/tb_lsu.sv
// Randomized and directed checks of lsu against an arithmetic reference model.
module tb_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    lsu_if bus();

    lsu #(.MISALIGN_CHK(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: sizes in bytes, lanes picked by dividing/shifting the data word
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         output bit ren, output bit wen, output logic [31:0] mwdata,
                         output logic [3:0] mask, output logic [31:0] res, output bit we,
                         output bit mis, output int lat);
        bit ld = 1'b0;
        bit st = 1'b0;
        int size = 0;
        int lo;
        logic [31:0] v;
        case (op)
            4'd0, 4'd4: begin ld = 1'b1; size = 1; end
            4'd1, 4'd5: begin ld = 1'b1; size = 2; end
            4'd2:       begin ld = 1'b1; size = 4; end
            4'd8:       begin st = 1'b1; size = 1; end
            4'd9:       begin st = 1'b1; size = 2; end
            4'd10:      begin st = 1'b1; size = 4; end
            default:    size = 0;
        endcase
        lo     = int'(addr[1:0]);
        mis    = (size == 2 && (lo % 2) == 1) || (size == 4 && lo != 0);
        ren    = ld && !mis;
        wen    = st && !mis;
        lat    = ren ? 2 : 1;
        mwdata = 32'h0;
        mask   = 4'h0;
        res    = 32'h0;
        we     = 1'b0;
        if (wen) begin
            case (size)
                1: begin mwdata = (wdata % 32'd256) * 32'h0101_0101;   mask = 4'(32'd1 << lo); end
                2: begin mwdata = (wdata % 32'd65536) * 32'h0001_0001; mask = 4'(32'd3 << ((lo / 2) * 2)); end
                default: begin mwdata = wdata; mask = 4'hF; end
            endcase
        end
        if (ren) begin
            v = rdata >> (8 * lo);
            case (size)
                1: begin
                    v = v % 32'd256;
                    if (op == 4'd0 && v >= 32'd128) v = v - 32'd256;
                end
                2: begin
                    v = v % 32'd65536;
                    if (op == 4'd1 && v >= 32'd32768) v = v - 32'd65536;
                end
                default: v = rdata;
            endcase
            res = v;
            we  = (rd != 5'd0);
        end
    endtask

    task automatic txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic [4:0] rd, input int hold);
        bit ren, wen, we, mis;
        logic [31:0] mwdata, res;
        logic [3:0] mask;
        int lat;
        model(op, addr, wdata, rdata, rd, ren, wen, mwdata, mask, res, we, mis, lat);
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_op_i     = op;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        bus.req_rd_i     = rd;
        bus.resp_ready_i = 1'b0;
        #1;
        chk("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
        chk("dmem_ren", 32'(bus.dmem_ren_o), 32'(ren));
        chk("dmem_wen", 32'(bus.dmem_wen_o), 32'(wen));
        if (ren || wen) chk("dmem_addr", bus.dmem_addr_o, addr & 32'hFFFF_FFFC);
        if (wen) begin
            chk("dmem_mask", 32'(bus.dmem_we_mask_o), 32'(mask));
            chk("dmem_wdata", bus.dmem_wdata_o, mwdata);
        end
        @(posedge clk);
        #1;
        bus.req_valid_i  = 1'b0;
        bus.dmem_rdata_i = rdata;
        @(negedge clk);
        chk("strobe_off", 32'({bus.dmem_ren_o, bus.dmem_wen_o}), 32'd0);
        if (lat == 2) begin
            chk("resp_early", 32'(bus.resp_valid_o), 32'd0);
            chk("ready_load", 32'(bus.req_ready_o), 32'd0);
            @(negedge clk);
        end
        bus.dmem_rdata_i = $urandom;
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            chk("resp_valid", 32'(bus.resp_valid_o), 32'd1);
            chk("resp_rdata", bus.resp_rdata_o, res);
            chk("resp_we", 32'(bus.resp_we_o), 32'(we));
            chk("resp_mis", 32'(bus.resp_misalign_o), 32'(mis));
            chk("resp_rd", 32'(bus.resp_rd_o), 32'(rd));
            chk("ready_resp", 32'(bus.req_ready_o), 32'd0);
        end
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        bus.resp_ready_i = 1'b0;
        chk("resp_clr", 32'(bus.resp_valid_o), 32'd0);
        chk("ready_back", 32'(bus.req_ready_o), 32'd1);
    endtask

    initial begin
        bus.req_valid_i  = 1'b1;
        bus.req_op_i     = 4'd2;
        bus.req_addr_i   = 32'h8000_0000;
        bus.req_wdata_i  = 32'h0;
        bus.req_rd_i     = 5'd1;
        bus.resp_ready_i = 1'b0;
        bus.dmem_rdata_i = 32'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_ren", 32'(bus.dmem_ren_o), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
        rst = 1'b0;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready_o), 32'd1);

        txn(4'd8, 32'h8000_0003, 32'h0000_00AB, 32'h0, 5'd2, 0);
        txn(4'd0, 32'h8000_0002, 32'h0, 32'h12F0_3456, 5'd5, 1);
        txn(4'd4, 32'h8000_0002, 32'h0, 32'h12F0_3456, 5'd5, 0);
        txn(4'd2, 32'h8000_0006, 32'h0, 32'h1111_2222, 5'd9, 0);
        txn(4'd1, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 5'd3, 5);
        txn(4'd15, 32'h8000_0000, 32'hDEAD_BEEF, 32'h5555_5555, 5'd4, 0);
        txn(4'd0, 32'h8000_0001, 32'h0, 32'h0000_8000, 5'd0, 0);

        // Reset while a load is in flight must drop it
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 4'd2;
        bus.req_addr_i  = 32'h8000_0010;
        bus.req_rd_i    = 5'd7;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_load_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_load_valid", 32'(bus.resp_valid_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_load_noresp", 32'(bus.resp_valid_o), 32'd0);
            chk("rst_load_idle", 32'(bus.req_ready_o), 32'd1);
        end

        for (int i = 0; i < 300; i++) begin
            txn(4'($urandom_range(0, 15)), 32'h8000_0000 | ($urandom & 32'h0000_0FFF),
                $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MISALIGN_CHK, default 1, meaning: 1 = detect and trap misaligned accesses, 0 = no check and force low address bits per REQ-014.
REQ-002 SHALL have ports: clk_i  in  1  single clock; rst_i  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: req_valid_i in 1 request valid; req_ready_o out 1 LSU can accept; req_op_i in 4 operation code; req_addr_i in 32 byte address; req_wdata_i in 32 store data; req_rd_i in 5 destination register.
REQ-004 SHALL have ports: resp_valid_o out 1; resp_ready_i in 1; resp_rdata_o out 32 load result; resp_rd_o out 5; resp_we_o out 1 register-write enable; resp_misalign_o out 1 trap flag.
REQ-005 SHALL have ports: dmem_ren_o out 1; dmem_wen_o out 1; dmem_addr_o out 32; dmem_wdata_o out 32; dmem_we_mask_o out 4; dmem_rdata_i in 32, valid in the cycle after dmem_ren_o is sampled.

Function
REQ-006 SHALL decode op codes as follows: 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; every other code is ILLEGAL.
REQ-007 SHALL implement an FSM with states IDLE, LOAD and RESP; req_ready_o = (state==IDLE) && !rst_i.
REQ-008 SHALL accept a request when req_valid_i && req_ready_o, and register op, addr[1:0] and rd on acceptance.
REQ-009 SHALL assert dmem strobes combinationally only in the accept cycle and drive them to 0 otherwise; dmem_addr_o = {req_addr_i[31:2],2'b00}.
REQ-010 SHALL, on an aligned load, assert dmem_ren_o, move IDLE->LOAD, and in LOAD capture formatted dmem_rdata_i into the response register and move to RESP; resp_valid_o rises 2 cycles after accept.
REQ-011 SHALL, on an aligned store, assert dmem_wen_o and move IDLE->RESP; resp_valid_o rises 1 cycle after accept, with resp_we_o=0 and resp_rdata_o=0.
REQ-012 SHALL drive store data and mask as follows: SB wdata={4{wdata[7:0]}}, mask=4'b0001<<addr[1:0]; SH wdata={2{wdata[15:0]}}, mask=4'b0011<<{addr[1],1'b0}; SW wdata unchanged, mask=4'b1111.
REQ-013 SHALL format loads from the byte lane selected by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes unchanged; resp_we_o = 1 when rd!=0.
REQ-014 SHALL, with MISALIGN_CHK=1, treat halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 as misaligned; a misaligned access asserts no strobe, goes IDLE->RESP, and responds with resp_misalign_o=1, resp_we_o=0, resp_rdata_o=0. With MISALIGN_CHK=0, the LSU SHALL clear addr[0] for halfword accesses and addr[1:0] for word accesses before lane selection.
REQ-015 SHALL treat an ILLEGAL op as a no-op: no strobe, IDLE->RESP, resp_we_o=0, resp_misalign_o=0, resp_rdata_o=0.
REQ-016 SHALL hold every resp_* output stable in RESP until resp_ready_i, then move RESP->IDLE; no accept occurs in the same cycle as that handshake.
REQ-017 SHALL assert at most one of dmem_ren_o and dmem_wen_o in any cycle.

Reset
REQ-018 SHALL, while rst_i is high at a clock edge, enter IDLE and clear all response registers; outputs SHALL be 0 in that cycle, including req_ready_o and all dmem strobes, regardless of req_valid_i.
REQ-019 SHALL, on reset in LOAD or RESP, discard the pending operation so that no response is ever issued for it.

Structure
REQ-020 SHALL place op encodings, the FSM state enum and byte-lane widths in package lsu_pkg.
REQ-021 SHALL implement store-data/mask generation and load extraction in one combinational sub-module, lsu_align, instantiated once.

Verification
REQ-022 SHALL verify: SB addr=0x80000003, wdata=0x000000AB -> dmem_wen_o=1, addr=0x80000000, mask=4'b1000, wdata=0xABABABAB; resp_valid 1 cycle later with we=0.
REQ-023 SHALL verify: LB addr=0x80000002, rd=5, dmem_rdata_i=0x12F03456 -> resp_rdata_o=0xFFFFFFF0, resp_we_o=1, resp_valid 2 cycles after accept; with LBU, resp_rdata_o=0x000000F0.
REQ-024 SHALL verify: LW addr=0x80000006 with MISALIGN_CHK=1 -> no strobe, resp_misalign_o=1, resp_we_o=0 at accept+1.
REQ-025 SHALL verify: LH addr=0x80000002 with resp_ready_i held low 5 cycles -> resp outputs stable, req_ready_o=0 throughout; accept resumes the cycle after the handshake.
REQ-026 SHALL verify: rst_i asserted in LOAD -> next cycle IDLE with resp_valid_o=0, and no response ever appears for that load.
REQ-027 SHALL verify: op=4'b1111 -> no strobe, resp at accept+1 with we=0, misalign=0, rdata=0.
